twiddle_gen: RTL

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/fft_pkg.sv | 66 ++++++
 rtl/twiddle_rom.sv | 22 ++
 rtl/twiddle_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types, sizes and the twiddle table generator.
// Twiddles are W = exp(-j*2*pi*e/N) in signed fixed point.
package fft_pkg;

  localparam int FFT_LOG2N = 4;
  localparam int DATA_WIDTH = 16;
  localparam int TWIDDLE_POWER = 16;
  localparam int TW_MAX = 2 ** (TWIDDLE_POWER - 1) - 1;

  localparam int MAX_LOG2N = 10;
  localparam int TAB_AW = MAX_LOG2N - 1;
  localparam int TAB_SIZE = 1 << TAB_AW;

  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic signed [TWIDDLE_POWER-1:0] cos;
    logic signed [TWIDDLE_POWER-1:0] sin;
  } twiddle_t;

  typedef twiddle_t [TAB_SIZE-1:0] twiddle_tab_t;

  typedef struct packed {
    logic                  valid;
    logic                  sw;
    logic [DATA_WIDTH-1:0] data;
  } pipe_t;

  localparam twiddle_t TW_ONE = '{
    cos: TWIDDLE_POWER'(TW_MAX),
    sin: '0
  };

  function automatic logic signed [TWIDDLE_POWER-1:0]
    round_sat(real x);
    int r;
    r = (x >= 0.0) ? $rtoi(x + 0.5)
                   : -$rtoi(0.5 - x);
    if (r > TW_MAX) r = TW_MAX;
    if (r < -TW_MAX) r = -TW_MAX;
    return TWIDDLE_POWER'(r);
  endfunction

  function automatic twiddle_t
    twiddle_entry(int e, int log2n);
    twiddle_t t;
    real ang;
    real scale;
    scale = real'(TW_MAX + 1);
    ang = 2.0 * PI * real'(e)
        / real'(1 << log2n);
    t.cos = round_sat($cos(ang) * scale);
    t.sin = -round_sat($sin(ang) * scale);
    return t;
  endfunction

  function automatic twiddle_tab_t
    twiddle_table(int log2n);
    twiddle_tab_t t;
    t = '0;
    for (int e = 0; e < (1 << (log2n - 1)); e++)
      t[e] = twiddle_entry(e, log2n);
    return t;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Synchronous-read twiddle table, N/2 entries indexed by exponent.
// One cycle from addr to data.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(LOG2N > 1 ? LOG2N-1 : 1)-1:0] addr,
  output twiddle_t            data
);

  localparam twiddle_tab_t TABLE =
    twiddle_table(LOG2N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= TW_ONE;
    else        data <= TABLE[TAB_AW'(addr)];
  end

endmodule

// File: rtl/twiddle_gen.sv
// SDF stage twiddle generator: pairs re/im samples, tracks the pair
// index and delivers the twiddle aligned with the im sample.
module twiddle_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int STAGE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sw,
  output twiddle_t              twiddle,
  output logic                  pair_err
);

  localparam int N = 1 << LOG2N;
  localparam int M = N >> STAGE;
  localparam int AW = LOG2N > 1 ? LOG2N - 1 : 1;
  localparam logic [LOG2N-1:0] HALF = LOG2N'(M / 2);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(M - 1);

  logic             phase;
  logic [LOG2N-1:0] j;
  logic             cur_phase;
  logic [LOG2N-1:0] cur_j;
  logic [LOG2N-1:0] j_next;
  logic [LOG2N-1:0] off;
  logic [AW-1:0]    e;
  pipe_t            s1;
  twiddle_t         rom_data;

  // sof overrides the running state for the sample it marks
  always_comb begin
    cur_phase = phase;
    cur_j     = j;
    if (in_valid && sof) begin
      cur_phase = 1'b0;
      cur_j     = '0;
    end
  end

  always_comb begin
    off    = cur_j - HALF;
    e      = '0;
    if (cur_j >= HALF) e = AW'(off << STAGE);
    j_next = (cur_j == LAST) ? '0 : cur_j + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      j        <= '0;
      pair_err <= 1'b0;
    end else if (in_valid) begin
      phase <= ~cur_phase;
      j     <= cur_phase ? j_next : cur_j;
      if (sof && phase) pair_err <= 1'b1;
    end else if (phase) begin
      pair_err <= 1'b1;
    end
  end

  twiddle_rom #(
    .LOG2N (LOG2N)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (e),
    .data  (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= in_valid;
      s1.sw    <= in_valid & cur_phase;
      s1.data  <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sw        <= 1'b0;
      dout      <= '0;
      twiddle   <= TW_ONE;
    end else begin
      out_valid <= s1.valid;
      sw        <= s1.sw;
      dout      <= s1.data;
      if (s1.valid && s1.sw) twiddle <= rom_data;
    end
  end

endmodule
